// File: rtl/fft_pkg.sv
// Shared constants, select encodings and FSM states for the 32-point radix-2 FFT datapath control.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fft_pkg;

    localparam int NUMSTAGES  = 5;
    localparam int ADDRSIZE   = 3;
    localparam int NUMSAMPLES = 32;
    localparam int NUMBANKS   = 4;

    // PE-input ordering selects (bank order presented to the butterfly)
    localparam logic [1:0] M1_ORD_0123 = 2'b00;
    localparam logic [1:0] M1_ORD_2031 = 2'b01;
    localparam logic [1:0] M1_ORD_0213 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } stage_state_t;

endpackage

// File: rtl/fft_stage_ctrl.sv
// Per-stage address/select sequencer for a 4-bank in-place radix-2 FFT (8 reads, then write-back).
// Latency: reads start 1 cycle after en_stage is sampled; writes trail reads by PIPE_LAT; done at 8+PIPE_LAT.
// Backpressure: none; en_stage low mid-stage aborts, ld_data high flushes everything back to IDLE.
module fft_stage_ctrl #(
    parameter int NUMSTAGES = fft_pkg::NUMSTAGES,
    parameter int ADDRSIZE  = fft_pkg::ADDRSIZE,
    parameter int PIPE_LAT  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_data,
    input  logic                en_stage,
    input  logic [2:0]          stage_num,
    output logic                m0_s,
    output logic [1:0]          m1_s,
    output logic                m2_s,
    output logic                m3_s,
    output logic [ADDRSIZE-1:0] r_addr_0_1,
    output logic [ADDRSIZE-1:0] r_addr_2_3,
    output logic [ADDRSIZE-1:0] w_addr_0_1,
    output logic [ADDRSIZE-1:0] w_addr_2_3,
    output logic                stage_done
);
    import fft_pkg::*;

    localparam int                  WORDS      = NUMSAMPLES / NUMBANKS;
    localparam logic [ADDRSIZE-1:0] C_LAST     = ADDRSIZE'(WORDS - 1);
    localparam logic [2:0]          LAST_STAGE = 3'(NUMSTAGES - 1);
    localparam int                  DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    // One in-flight write-back: valid flag plus the addresses that were read for it
    typedef struct packed {
        logic                vld;
        logic [ADDRSIZE-1:0] a01;
        logic [ADDRSIZE-1:0] a23;
    } wr_slot_t;

    stage_state_t        state;
    logic [ADDRSIZE-1:0] c;
    logic [DW-1:0]       drain_cnt;
    logic                live;
    wr_slot_t            pipe [PIPE_LAT];
    wr_slot_t            slot_in;
    logic                flush;

    logic [2:0]          stage_eff;
    logic [ADDRSIZE-1:0] stage_mask;
    logic [1:0]          m1_nat;
    logic                m2_nat;

    // Decode the effective stage: early stages pair words across addresses (XOR twist),
    // later stages pair words across banks at the same address.
    always_comb begin
        stage_eff  = (stage_num > LAST_STAGE) ? LAST_STAGE : stage_num;
        stage_mask = '0;
        m1_nat     = M1_ORD_0123;
        m2_nat     = 1'b1;
        if (stage_eff < 3'(ADDRSIZE)) begin
            stage_mask = ADDRSIZE'(WORDS / 2) >> stage_eff;
            m1_nat     = M1_ORD_2031;
            m2_nat     = 1'b0;
        end else if (stage_eff == LAST_STAGE - 3'd1) begin
            m1_nat = M1_ORD_0213;
        end
    end

    // Orderings follow stage_num directly; held at zero until the first clock after reset
    assign m1_s = live ? m1_nat : M1_ORD_0123;
    assign m2_s = live & m2_nat;

    // Stage sequencer: IDLE -> READ (8 words) -> DRAIN (pipeline empties) -> DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            c          <= '0;
            drain_cnt  <= '0;
            live       <= 1'b0;
            r_addr_0_1 <= '0;
            r_addr_2_3 <= '0;
            m0_s       <= 1'b0;
            stage_done <= 1'b0;
        end else begin
            live <= 1'b1;
            if (ld_data) begin
                state      <= ST_IDLE;
                c          <= '0;
                m0_s       <= 1'b0;
                stage_done <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (en_stage) begin
                            state      <= ST_READ;
                            c          <= '0;
                            r_addr_0_1 <= '0;
                            r_addr_2_3 <= stage_mask;
                            m0_s       <= 1'b1;
                        end
                    end
                    ST_READ: begin
                        if (!en_stage) begin
                            state <= ST_IDLE;
                            m0_s  <= 1'b0;
                        end else if (c == C_LAST) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end else begin
                            c          <= c + 1'b1;
                            r_addr_0_1 <= c + 1'b1;
                            r_addr_2_3 <= (c + 1'b1) ^ stage_mask;
                        end
                    end
                    ST_DRAIN: begin
                        if (!en_stage) begin
                            state <= ST_IDLE;
                            m0_s  <= 1'b0;
                        end else if (drain_cnt == DW'(PIPE_LAT - 1)) begin
                            state      <= ST_DONE;
                            stage_done <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (!en_stage) begin
                            state      <= ST_IDLE;
                            stage_done <= 1'b0;
                            m0_s       <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Entry into the write-delay line: current read addresses, valid only while reading
    always_comb begin
        slot_in     = '0;
        slot_in.vld = (state == ST_READ);
        slot_in.a01 = r_addr_0_1;
        slot_in.a23 = r_addr_2_3;
        flush       = ld_data | (((state == ST_READ) || (state == ST_DRAIN)) & ~en_stage);
    end

    // Write-delay line: replays read addresses PIPE_LAT cycles later; emptied on load or abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= slot_in;
            for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign m3_s       = pipe[PIPE_LAT-1].vld;
    assign w_addr_0_1 = pipe[PIPE_LAT-1].a01;
    assign w_addr_2_3 = pipe[PIPE_LAT-1].a23;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Bench for fft_stage_ctrl: directed scenarios plus randomized stage runs, aborts and loads,
// all checked against a cycle-count reference model of the stage timeline.
module tb_fft_stage_ctrl;

    localparam int P = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ld_data;
    logic       en_stage;
    logic [2:0] stage_num;
    logic       m0_s;
    logic [1:0] m1_s;
    logic       m2_s;
    logic       m3_s;
    logic [2:0] r_addr_0_1;
    logic [2:0] r_addr_2_3;
    logic [2:0] w_addr_0_1;
    logic [2:0] w_addr_2_3;
    logic       stage_done;

    fft_stage_ctrl #(.NUMSTAGES(5), .ADDRSIZE(3), .PIPE_LAT(P)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_data    (ld_data),
        .en_stage   (en_stage),
        .stage_num  (stage_num),
        .m0_s       (m0_s),
        .m1_s       (m1_s),
        .m2_s       (m2_s),
        .m3_s       (m3_s),
        .r_addr_0_1 (r_addr_0_1),
        .r_addr_2_3 (r_addr_2_3),
        .w_addr_0_1 (w_addr_0_1),
        .w_addr_2_3 (w_addr_2_3),
        .stage_done (stage_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: a stage is a timeline counted in clock edges since en_stage was taken
    bit         m_live, m_act, m_done, m_m0;
    int         m_k;
    logic [2:0] m_r01, m_r23;

    // Per-bank/per-address access tallies for one stage
    int rd_cnt [4][8];
    int wr_cnt [4][8];
    bit cov_on;

    function automatic int eff_stage(input logic [2:0] s);
        return (s > 3'd4) ? 4 : int'(s);
    endfunction

    // Butterfly partner distance in address space for stages 0..2, none for 3..4
    function automatic logic [2:0] twist(input logic [2:0] s);
        int e = eff_stage(s);
        return (e <= 2) ? 3'(4 >> e) : 3'd0;
    endfunction

    function automatic logic [1:0] m1_ref(input logic [2:0] s);
        int e = eff_stage(s);
        if (e <= 2) return 2'b01;
        if (e == 3) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_live = 0; m_act = 0; m_done = 0; m_m0 = 0; m_k = 0;
        m_r01 = 3'd0; m_r23 = 3'd0;
    endtask

    task automatic model_edge(input logic en, input logic ld);
        if (rst_n) begin
            m_live = 1;
            if (ld) begin
                m_act = 0; m_done = 0; m_m0 = 0;
            end else if (m_act) begin
                if (!en) begin
                    m_act = 0; m_m0 = 0;
                end else begin
                    m_k++;
                    if (m_k <= 7) begin
                        m_r01 = 3'(m_k);
                        m_r23 = 3'(m_k) ^ twist(stage_num);
                    end
                    if (m_k == 8 + P) begin
                        m_act = 0; m_done = 1;
                    end
                end
            end else if (m_done) begin
                if (!en) begin
                    m_done = 0; m_m0 = 0;
                end
            end else if (en) begin
                m_act = 1; m_k = 0; m_m0 = 1;
                m_r01 = 3'd0;
                m_r23 = twist(stage_num);
            end
        end
    endtask

    task automatic check_outputs();
        bit         m3e;
        logic [2:0] wi;
        m3e = m_act && (m_k >= P) && (m_k <= P + 7);
        check("m0_s", m0_s, m_m0);
        check("m1_s", m1_s, m_live ? m1_ref(stage_num) : 2'b00);
        check("m2_s", m2_s, (m_live && eff_stage(stage_num) >= 3) ? 1'b1 : 1'b0);
        check("m3_s", m3_s, m3e);
        check("stage_done", stage_done, m_done);
        check("r_addr_0_1", r_addr_0_1, m_r01);
        check("r_addr_2_3", r_addr_2_3, m_r23);
        if (m3e) begin
            wi = 3'(m_k - P);
            check("w_addr_0_1", w_addr_0_1, wi);
            check("w_addr_2_3", w_addr_2_3, wi ^ twist(stage_num));
        end
        if (cov_on) begin
            if (m_act && m_k <= 7) begin
                rd_cnt[0][r_addr_0_1]++; rd_cnt[1][r_addr_0_1]++;
                rd_cnt[2][r_addr_2_3]++; rd_cnt[3][r_addr_2_3]++;
            end
            if (m3_s === 1'b1) begin
                wr_cnt[0][w_addr_0_1]++; wr_cnt[1][w_addr_0_1]++;
                wr_cnt[2][w_addr_2_3]++; wr_cnt[3][w_addr_2_3]++;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".m0_s"}, m0_s, 1'b0);
        check({tag, ".m1_s"}, m1_s, 2'b00);
        check({tag, ".m2_s"}, m2_s, 1'b0);
        check({tag, ".m3_s"}, m3_s, 1'b0);
        check({tag, ".stage_done"}, stage_done, 1'b0);
        check({tag, ".r_addr_0_1"}, r_addr_0_1, 3'd0);
        check({tag, ".r_addr_2_3"}, r_addr_2_3, 3'd0);
        check({tag, ".w_addr_0_1"}, w_addr_0_1, 3'd0);
        check({tag, ".w_addr_2_3"}, w_addr_2_3, 3'd0);
    endtask

    // Drive inputs, take one clock edge, then compare just after it
    task automatic step(input logic en, input logic ld);
        en_stage = en;
        ld_data  = ld;
        @(posedge clk);
        #1;
        model_edge(en, ld);
        check_outputs();
    endtask

    initial begin
        int hold, gap, cut, bad_rd, bad_wr, mode;

        rst_n = 1'b0; en_stage = 1'b0; ld_data = 1'b0; stage_num = 3'd0; cov_on = 0;
        model_reset();
        #1;
        check_reset("reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step(0, 0);
        step(0, 0);

        // Stage 0, held through done: reads 0..7 / 4..7,0..3, done on edge 10
        stage_num = 3'd0;
        repeat (12) step(1, 0);
        check("stage0_done_held", stage_done, 1'b1);
        step(0, 0);

        // Reset asserted mid-read (stage 2, c=3), then a clean restart from c=0
        stage_num = 3'd2;
        repeat (4) step(1, 0);
        check("pre_reset_r01", r_addr_0_1, 3'd3);
        en_stage = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset("midread_reset");
        @(posedge clk);
        #1;
        check_reset("held_reset");
        #3 rst_n = 1'b1;
        step(0, 0);
        step(1, 0);
        check("restart_r01", r_addr_0_1, 3'd0);
        check("restart_r23", r_addr_2_3, 3'd1);
        repeat (11) step(1, 0);
        step(0, 0);

        // All five stages back to back, each bank address read and written exactly once
        for (int s = 0; s < 5; s++) begin
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 8; a++) begin
                    rd_cnt[b][a] = 0; wr_cnt[b][a] = 0;
                end
            stage_num = 3'(s);
            cov_on = 1;
            repeat (13) step(1, 0);
            check("done_held_en_high", stage_done, 1'b1);
            step(0, 0);
            check("done_cleared_en_low", stage_done, 1'b0);
            cov_on = 0;
            bad_rd = 0; bad_wr = 0;
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 8; a++) begin
                    if (rd_cnt[b][a] != 1) bad_rd++;
                    if (wr_cnt[b][a] != 1) bad_wr++;
                end
            check("reads_not_once", 8'(bad_rd), 8'd0);
            check("writes_not_once", 8'(bad_wr), 8'd0);
        end

        // Load arriving during drain: selects drop next cycle, no done
        stage_num = 3'd1;
        repeat (9) step(1, 0);
        step(1, 1);
        check("ld_drain_m0", m0_s, 1'b0);
        check("ld_drain_m3", m3_s, 1'b0);
        repeat (3) step(0, 0);
        check("ld_drain_no_done", stage_done, 1'b0);

        // Randomized runs: full stages, aborts at random points, loads at random points
        for (int run = 0; run < 40; run++) begin
            stage_num = 3'($urandom_range(0, 7));
            mode = $urandom_range(0, 2);
            gap  = $urandom_range(1, 3);
            if (mode == 0) begin
                hold = 11 + $urandom_range(0, 3);
                repeat (hold) step(1, 0);
            end else if (mode == 1) begin
                cut = $urandom_range(1, 9);
                repeat (cut) step(1, 0);
            end else begin
                cut = $urandom_range(1, 11);
                repeat (cut) step(1, 0);
                step($urandom_range(0, 1), 1);
                repeat ($urandom_range(0, 4)) step(1, 0);
            end
            repeat (gap) step(0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
